io_device_regs: RTL and testbench
=================================

IO_DEVICE_REGS -- requirements
Module: io_device_regs

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-low, and all state changes occur only on the rising edge of CLK.
REQ-002 Port CLK, input, 1 bit: system clock.
REQ-003 Port RESET_N, input, 1 bit: synchronous active-low reset.
REQ-004 Port MAR, input, 16 bits: current memory address.
REQ-005 Port BUS, input, 16 bits: write data.
REQ-006 Port MEM_ACC, input, 1 bit: memory access strobe, valid for one cycle.
REQ-007 Port R_W, input, 1 bit: access type, 1 = write, 0 = read.
REQ-008 Port KB_DATA, input, 8 bits: keyboard character.
REQ-009 Port KB_VALID, input, 1 bit: keyboard character offered.
REQ-010 Port KB_READY, output, 1 bit: keyboard character accepted this cycle if KB_VALID.
REQ-011 Port DISP_ACK, input, 1 bit: display consumed DDR.
REQ-012 Port DDR_OUT, output, 8 bits: display character.
REQ-013 Port DDR_VALID, output, 1 bit: display character pending.
REQ-014 Port KBDR_OUT, output, 16 bits: KBDR register value.
REQ-015 Port KBSR_OUT, output, 16 bits: KBSR register value.
REQ-016 Port DSR_OUT, output, 16 bits: DSR register value.
REQ-017 Port INMUX_SEL, output, 2 bits: read-source select (00 KBDR, 01 KBSR, 10 DSR, 11 memory).
REQ-018 Port MEM_WE, output, 1 bit: memory write enable, qualified against device addresses.
REQ-019 Port INTR, output, 1 bit: keyboard interrupt request; present only under KB_INTR_EN.

Function
REQ-020 Address decode SHALL map KBSR=xFE00, KBDR=xFE02, DSR=xFE04, DDR=xFE06; all other addresses are memory.
REQ-021 INMUX_SEL SHALL be combinational from MAR alone: xFE02->00, xFE00->01, xFE04->10, any other address (including xFE06)->11.
REQ-022 MEM_WE SHALL equal MEM_ACC & R_W & (MAR not a device address), combinationally.
REQ-023 KBDR_OUT SHALL be {8'h00,KBDR}, KBSR_OUT SHALL be {KBSR[15],KBSR[14],14'b0}, and DSR_OUT SHALL be {DSR[15],15'b0}; all three are direct register outputs with 0-cycle read latency.
REQ-024 KB_READY SHALL equal ~KBSR[15].
REQ-025 When KB_VALID & KB_READY, KBDR SHALL load KB_DATA and KBSR[15] SHALL be set at the next edge.
REQ-026 When MEM_ACC & ~R_W & MAR=xFE02, KBSR[15] SHALL clear at the next edge; because KB_READY is 0 whenever KBSR[15] is 1, a load and a clear cannot coincide.
REQ-027 The display FSM SHALL have two states, IDLE (DSR[15]=1, DDR_VALID=0) and BUSY (DSR[15]=0, DDR_VALID=1).
REQ-028 IDLE->BUSY SHALL occur on MEM_ACC & R_W & MAR=xFE06, with DDR loading BUS[7:0] at the same edge.
REQ-029 BUSY->IDLE SHALL occur on the edge where DISP_ACK=1; DISP_ACK in IDLE SHALL be ignored.
REQ-030 A DDR write in BUSY SHALL be dropped, leaving DDR, DDR_VALID and DSR unchanged.
REQ-031 Writes to KBDR and DSR SHALL be ignored, and writes to KBSR SHALL be ignored except as defined in REQ-038.
REQ-032 DDR_OUT SHALL be held stable while DDR_VALID=1.

Reset
REQ-033 On an edge with RESET_N=0, the registers SHALL take KBSR=x0000, KBDR=x00, DDR=x00, DSR[15]=1 (FSM IDLE), DDR_VALID=0 and INTR=0.
REQ-034 As a consequence of REQ-033, KB_READY SHALL read 1 after reset.
REQ-035 Reset SHALL take priority over every other event in the same cycle.
REQ-036 Reset while BUSY SHALL discard the pending character with DDR_VALID=0 on the next cycle, and reset while KBSR[15]=1 SHALL discard the buffered key.

Configuration
REQ-037 The optional feature SHALL be controlled by macro KB_INTR_EN.
REQ-038 With KB_INTR_EN defined: KBSR[14] is the interrupt enable, written from BUS[14] on MEM_ACC & R_W & MAR=xFE00; INTR is registered and equals KBSR[15] & KBSR[14] one cycle later.
REQ-039 Without KB_INTR_EN: the INTR port is absent, KBSR[14] reads 0, and KBSR writes have no effect.

Verification
REQ-040 Reset: hold RESET_N=0 for 2 cycles -> DSR_OUT=x8000, KBSR_OUT=x0000, KB_READY=1, DDR_VALID=0.
REQ-041 Keyboard path: KB_DATA=x41 with KB_VALID for 1 cycle -> next cycle KBSR_OUT=x8000, KBDR_OUT=x0041, KB_READY=0; then read xFE02 -> INMUX_SEL=00 during the access and KBSR_OUT=x0000 on the next cycle.
REQ-042 Display path: write BUS=x1234 to xFE06 -> DDR_OUT=x34, DDR_VALID=1, DSR_OUT=x0000; a second write of x0055 is dropped; DISP_ACK -> next cycle DSR_OUT=x8000, DDR_VALID=0.
REQ-043 Decode and write gating: MEM_ACC with R_W=1 at MAR=xFE06 gives MEM_WE=0, at MAR=x3000 gives MEM_WE=1 and INMUX_SEL=11, and MAR=xFE04 gives INMUX_SEL=10.
REQ-044 Reset mid-operation: assert RESET_N=0 while BUSY and while KBSR[15]=1 -> next cycle DDR_VALID=0, DSR_OUT=x8000, KBSR_OUT=x0000.
REQ-045 Interrupt (KB_INTR_EN defined): write x4000 to xFE00, then send a key -> INTR=1 one cycle after KBSR[15] sets, and INTR=0 one cycle after the KBDR read.

Source files
------------

// File: rtl/io_device_regs.sv
// Memory-mapped keyboard/display device registers: KBSR, KBDR, DSR and DDR.
// Optional keyboard interrupt (KBSR[14] enable plus INTR port) is enabled by defining KB_INTR_EN.
module io_device_regs (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] MAR,
    input  logic [15:0] BUS,
    input  logic        MEM_ACC,
    input  logic        R_W,
    input  logic [7:0]  KB_DATA,
    input  logic        KB_VALID,
    output logic        KB_READY,
    input  logic        DISP_ACK,
    output logic [7:0]  DDR_OUT,
    output logic        DDR_VALID,
    output logic [15:0] KBDR_OUT,
    output logic [15:0] KBSR_OUT,
    output logic [15:0] DSR_OUT,
    output logic [1:0]  INMUX_SEL,
    output logic        MEM_WE
`ifdef KB_INTR_EN
   ,output logic        INTR
`endif
);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic {IDLE, BUSY} disp_state_t;

    disp_state_t state;
    logic        kb_full;
    logic        kb_ie;
    logic [7:0]  kbdr;
    logic [7:0]  ddr;
    logic        ddr_valid;
    logic        dsr_ready;

    logic is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;
    logic kb_load, kb_read, ddr_write;

    assign is_kbsr = (MAR == KBSR_ADDR);
    assign is_kbdr = (MAR == KBDR_ADDR);
    assign is_dsr  = (MAR == DSR_ADDR);
    assign is_ddr  = (MAR == DDR_ADDR);
    assign is_dev  = is_kbsr | is_kbdr | is_dsr | is_ddr;

    // DDR is write-only, so a read of it falls through to the memory source.
    always_comb begin
        INMUX_SEL = 2'b11;
        if (is_kbdr)
            INMUX_SEL = 2'b00;
        else if (is_kbsr)
            INMUX_SEL = 2'b01;
        else if (is_dsr)
            INMUX_SEL = 2'b10;
    end

    assign MEM_WE    = MEM_ACC & R_W & ~is_dev;
    assign kb_load   = KB_VALID & ~kb_full;
    assign kb_read   = MEM_ACC & ~R_W & is_kbdr;
    assign ddr_write = MEM_ACC & R_W & is_ddr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            kb_full <= 1'b0;
            kbdr    <= 8'h00;
        end else if (kb_load) begin
            kbdr    <= KB_DATA;
            kb_full <= 1'b1;
        end else if (kb_read) begin
            kb_full <= 1'b0;
        end
    end

`ifdef KB_INTR_EN
    // INTR lags the status bits by one cycle because it is computed from their registered values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            kb_ie <= 1'b0;
            INTR  <= 1'b0;
        end else begin
            if (MEM_ACC && R_W && is_kbsr)
                kb_ie <= BUS[14];
            INTR <= kb_full & kb_ie;
        end
    end
`else
    assign kb_ie = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            ddr       <= 8'h00;
            ddr_valid <= 1'b0;
            dsr_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ddr_write) begin
                        ddr       <= BUS[7:0];
                        state     <= BUSY;
                        ddr_valid <= 1'b1;
                        dsr_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (DISP_ACK) begin
                        state     <= IDLE;
                        ddr_valid <= 1'b0;
                        dsr_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ddr_valid <= 1'b0;
                    dsr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign KB_READY  = ~kb_full;
    assign KBDR_OUT  = {8'h00, kbdr};
    assign KBSR_OUT  = {kb_full, kb_ie, 14'b0};
    assign DSR_OUT   = {dsr_ready, 15'b0};
    assign DDR_OUT   = ddr;
    assign DDR_VALID = ddr_valid;

    // Only BUS[7:0] (and BUS[14] with the interrupt option) carry meaning here.
    logic unused_bus;
    assign unused_bus = &{1'b0, BUS[15:8]};

endmodule

// File: tb/tb_io_device_regs.sv
// Scoreboard bench for io_device_regs: directed vectors queue expected values, a negedge monitor compares.
// Define KB_INTR_EN to also exercise the keyboard interrupt.
module tb_io_device_regs;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] MAR;
    logic [15:0] BUS;
    logic        MEM_ACC;
    logic        R_W;
    logic [7:0]  KB_DATA;
    logic        KB_VALID;
    logic        KB_READY;
    logic        DISP_ACK;
    logic [7:0]  DDR_OUT;
    logic        DDR_VALID;
    logic [15:0] KBDR_OUT;
    logic [15:0] KBSR_OUT;
    logic [15:0] DSR_OUT;
    logic [1:0]  INMUX_SEL;
    logic        MEM_WE;
`ifdef KB_INTR_EN
    logic        INTR;
`endif

    io_device_regs dut (
        .CLK(CLK), .RESET_N(RESET_N), .MAR(MAR), .BUS(BUS),
        .MEM_ACC(MEM_ACC), .R_W(R_W), .KB_DATA(KB_DATA), .KB_VALID(KB_VALID),
        .KB_READY(KB_READY), .DISP_ACK(DISP_ACK), .DDR_OUT(DDR_OUT),
        .DDR_VALID(DDR_VALID), .KBDR_OUT(KBDR_OUT), .KBSR_OUT(KBSR_OUT),
        .DSR_OUT(DSR_OUT), .INMUX_SEL(INMUX_SEL), .MEM_WE(MEM_WE)
`ifdef KB_INTR_EN
       ,.INTR(INTR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef enum int {S_KB_READY, S_DDR_OUT, S_DDR_VALID, S_KBDR, S_KBSR, S_DSR, S_INMUX, S_MEM_WE, S_INTR} sig_t;

    typedef struct {
        string       name;
        sig_t        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] actual_of(sig_t sel);
        case (sel)
            S_KB_READY:  return {15'b0, KB_READY};
            S_DDR_OUT:   return {8'h00, DDR_OUT};
            S_DDR_VALID: return {15'b0, DDR_VALID};
            S_KBDR:      return KBDR_OUT;
            S_KBSR:      return KBSR_OUT;
            S_DSR:       return DSR_OUT;
            S_INMUX:     return {14'b0, INMUX_SEL};
            S_MEM_WE:    return {15'b0, MEM_WE};
`ifdef KB_INTR_EN
            S_INTR:      return {15'b0, INTR};
`endif
            default:     return 16'hxxxx;
        endcase
    endfunction

    // Monitor: every cycle, drain whatever the stimulus queued for this cycle and compare.
    always @(negedge CLK) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = sb_q.pop_front();
            act = actual_of(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic applyStimulus(input logic rst_n, input logic [15:0] mar, input logic [15:0] bus,
                                 input logic acc, input logic rw, input logic [7:0] kb_data,
                                 input logic kb_valid, input logic ack);
        @(posedge CLK);
        #1;
        RESET_N  = rst_n;
        MAR      = mar;
        BUS      = bus;
        MEM_ACC  = acc;
        R_W      = rw;
        KB_DATA  = kb_data;
        KB_VALID = kb_valid;
        DISP_ACK = ack;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input sig_t sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET_N = 1'b0; MAR = 16'h0; BUS = 16'h0; MEM_ACC = 1'b0; R_W = 1'b0;
        KB_DATA = 8'h0; KB_VALID = 1'b0; DISP_ACK = 1'b0;

        // Reset held for two cycles
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        checkOutput("rst_dsr", S_DSR, 16'h8000);
        checkOutput("rst_kbsr", S_KBSR, 16'h0000);
        checkOutput("rst_kb_ready", S_KB_READY, 16'h0001);
        checkOutput("rst_ddr_valid", S_DDR_VALID, 16'h0000);
        checkOutput("rst_kbdr", S_KBDR, 16'h0000);
        checkOutput("rst_ddr_out", S_DDR_OUT, 16'h0000);

        // Keyboard path
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0);
        checkOutput("kb_ready_before", S_KB_READY, 16'h0001);
        idle();
        checkOutput("kb_kbsr_full", S_KBSR, 16'h8000);
        checkOutput("kb_kbdr", S_KBDR, 16'h0041);
        checkOutput("kb_ready_full", S_KB_READY, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
        checkOutput("kb_ready_offer_full", S_KB_READY, 16'h0000);
        applyStimulus(1'b1, 16'hFE02, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("kb_read_inmux", S_INMUX, 16'h0000);
        checkOutput("kb_no_overwrite", S_KBDR, 16'h0041);
        checkOutput("kb_read_mem_we", S_MEM_WE, 16'h0000);
        checkOutput("kb_kbsr_during_read", S_KBSR, 16'h8000);
        idle();
        checkOutput("kb_kbsr_cleared", S_KBSR, 16'h0000);
        checkOutput("kb_ready_again", S_KB_READY, 16'h0001);
        checkOutput("kb_kbdr_kept", S_KBDR, 16'h0041);

        // Display path
        applyStimulus(1'b1, 16'hFE06, 16'h1234, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("ddr_wr_mem_we", S_MEM_WE, 16'h0000);
        checkOutput("ddr_wr_inmux", S_INMUX, 16'h0003);
        checkOutput("ddr_valid_before", S_DDR_VALID, 16'h0000);
        applyStimulus(1'b1, 16'hFE06, 16'h0055, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("ddr_out", S_DDR_OUT, 16'h0034);
        checkOutput("ddr_valid", S_DDR_VALID, 16'h0001);
        checkOutput("dsr_busy", S_DSR, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ddr_drop_out", S_DDR_OUT, 16'h0034);
        checkOutput("ddr_drop_valid", S_DDR_VALID, 16'h0001);
        checkOutput("ddr_drop_dsr", S_DSR, 16'h0000);
        idle();
        checkOutput("ack_dsr", S_DSR, 16'h8000);
        checkOutput("ack_ddr_valid", S_DDR_VALID, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        checkOutput("idle_ack_dsr", S_DSR, 16'h8000);
        checkOutput("idle_ack_valid", S_DDR_VALID, 16'h0000);

        // Decode and write gating
        applyStimulus(1'b1, 16'h3000, 16'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("mem_we_ram", S_MEM_WE, 16'h0001);
        checkOutput("inmux_ram", S_INMUX, 16'h0003);
        applyStimulus(1'b1, 16'hFE04, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("inmux_dsr", S_INMUX, 16'h0002);
        checkOutput("mem_we_dsr_rd", S_MEM_WE, 16'h0000);
        applyStimulus(1'b1, 16'hFE00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("inmux_kbsr", S_INMUX, 16'h0001);
        applyStimulus(1'b1, 16'h3000, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("mem_we_ram_read", S_MEM_WE, 16'h0000);
        applyStimulus(1'b1, 16'h3000, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("mem_we_no_acc", S_MEM_WE, 16'h0000);
        applyStimulus(1'b1, 16'hFE02, 16'hFFFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("mem_we_kbdr", S_MEM_WE, 16'h0000);
        applyStimulus(1'b1, 16'hFE04, 16'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        idle();
        checkOutput("kbdr_write_ignored", S_KBDR, 16'h0041);
        checkOutput("dsr_write_ignored", S_DSR, 16'h8000);
        checkOutput("kbsr_after_writes", S_KBSR, 16'h0000);

        // Reset mid-operation, with competing events in the reset cycle
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hFE06, 16'h00AB, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hFE06, 16'h00CD, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("pre_rst_kbsr", S_KBSR, 16'h8000);
        checkOutput("pre_rst_ddr_valid", S_DDR_VALID, 16'h0001);
        checkOutput("pre_rst_ddr_out", S_DDR_OUT, 16'h00AB);
        idle();
        checkOutput("mid_rst_ddr_valid", S_DDR_VALID, 16'h0000);
        checkOutput("mid_rst_dsr", S_DSR, 16'h8000);
        checkOutput("mid_rst_kbsr", S_KBSR, 16'h0000);
        checkOutput("mid_rst_kbdr", S_KBDR, 16'h0000);
        checkOutput("mid_rst_ddr_out", S_DDR_OUT, 16'h0000);

        // KBSR write: sets only the interrupt enable when that option is built in
        applyStimulus(1'b1, 16'hFE00, 16'hC000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("mem_we_kbsr", S_MEM_WE, 16'h0000);
        idle();
`ifdef KB_INTR_EN
        checkOutput("kbsr_ie_write", S_KBSR, 16'h4000);
`else
        checkOutput("kbsr_write_ignored", S_KBSR, 16'h0000);
`endif
        checkOutput("kbsr_write_ready", S_KB_READY, 16'h0001);

`ifdef KB_INTR_EN
        // Interrupt timing: INTR trails KBSR[15] by one cycle in both directions
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
        checkOutput("intr_idle", S_INTR, 16'h0000);
        idle();
        checkOutput("intr_kbsr_full", S_KBSR, 16'hC000);
        checkOutput("intr_lag", S_INTR, 16'h0000);
        idle();
        checkOutput("intr_set", S_INTR, 16'h0001);
        applyStimulus(1'b1, 16'hFE02, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("intr_during_read", S_INTR, 16'h0001);
        idle();
        checkOutput("intr_kbsr_read", S_KBSR, 16'h4000);
        checkOutput("intr_hold", S_INTR, 16'h0001);
        idle();
        checkOutput("intr_clear", S_INTR, 16'h0000);
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(posedge CLK);
        @(posedge CLK);
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
